// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate extension pipeline.
// IMM_EXT_TRUNC_CHECK_EN is handled in the users of this package.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO = 2'd0,
        IMM_SIGN = 2'd1,
        IMM_LUI  = 2'd2,
        IMM_BR   = 2'd3
    } imm_mode_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_TWO   = 2'd2;

    localparam int BR_SHIFT = 2;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: zero, sign, upper-load, branch.
// IMM_EXT_TRUNC_CHECK_EN adds the trunc flag for lost significant bits.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  imm_mode_t         mode,
    input  logic [IN_W-1:0]   imm,
    output logic [OUT_W-1:0]  result
`ifdef IMM_EXT_TRUNC_CHECK_EN
    ,
    output logic              trunc
`endif
);

    logic [OUT_W-1:0] zx_val;
    logic [OUT_W-1:0] sx_val;
    logic [OUT_W-1:0] lui_val;
    logic [OUT_W-1:0] br_val;

    assign zx_val  = OUT_W'(imm);
    assign sx_val  = OUT_W'($signed(imm));
    assign lui_val = OUT_W'((OUT_W+IN_W)'(imm) << IN_W);
    assign br_val  = OUT_W'((OUT_W+BR_SHIFT)'($signed(imm)) << BR_SHIFT);

    // Select the extended operand for the requested mode
    always_comb begin
        result = '0;
        unique case (1'b1)
            mode == IMM_ZERO: result = zx_val;
            mode == IMM_SIGN: result = sx_val;
            mode == IMM_LUI:  result = lui_val;
            mode == IMM_BR:   result = br_val;
            default:          result = '0;
        endcase
    end

`ifdef IMM_EXT_TRUNC_CHECK_EN
    // Bits shifted out above OUT_W, plus the kept MSB for the branch case
    logic [IN_W-1:0]     lui_hi;
    logic [BR_SHIFT:0]   br_top;

    assign lui_hi = IN_W'(((OUT_W+IN_W)'(imm) << IN_W) >> OUT_W);
    assign br_top = (BR_SHIFT+1)'(
        ((OUT_W+BR_SHIFT)'($signed(imm)) << BR_SHIFT) >> (OUT_W-1));

    // Flag results whose dropped high bits carried information
    always_comb begin
        trunc = 1'b0;
        unique case (1'b1)
            mode == IMM_LUI: trunc = |lui_hi;
            mode == IMM_BR:  trunc = !((br_top == '0) || (br_top == '1));
            default:         trunc = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator with valid/ready and a 2-entry skid buffer.
// IMM_EXT_TRUNC_CHECK_EN adds the out_trunc port and its registers.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [IN_W-1:0]   in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_imm,
    output logic [1:0]        out_mode
`ifdef IMM_EXT_TRUNC_CHECK_EN
    ,
    output logic              out_trunc
`endif
);

    state_t            state;
    logic [OUT_W-1:0]  res_imm;
    logic [OUT_W-1:0]  m_imm;
    logic [OUT_W-1:0]  s_imm;
    logic [1:0]        m_mode;
    logic [1:0]        s_mode;
    logic              in_xfer;
    logic              out_xfer;
`ifdef IMM_EXT_TRUNC_CHECK_EN
    logic              res_trunc;
    logic              m_trunc;
    logic              s_trunc;
`endif

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode   (imm_mode_t'(in_mode)),
        .imm    (in_imm),
        .result (res_imm)
`ifdef IMM_EXT_TRUNC_CHECK_EN
        ,
        .trunc  (res_trunc)
`endif
    );

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_imm   = m_imm;
    assign out_mode  = m_mode;
`ifdef IMM_EXT_TRUNC_CHECK_EN
    assign out_trunc = m_trunc;
`endif

    // Occupancy FSM: load M directly, park in S when M is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            m_imm   <= '0;
            m_mode  <= '0;
            s_imm   <= '0;
            s_mode  <= '0;
`ifdef IMM_EXT_TRUNC_CHECK_EN
            m_trunc <= 1'b0;
            s_trunc <= 1'b0;
`endif
        end else begin
            unique case (1'b1)
                state == ST_EMPTY: begin
                    if (in_xfer) begin
                        m_imm   <= res_imm;
                        m_mode  <= in_mode;
`ifdef IMM_EXT_TRUNC_CHECK_EN
                        m_trunc <= res_trunc;
`endif
                        state   <= ST_ONE;
                    end
                end
                state == ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_imm   <= res_imm;
                        m_mode  <= in_mode;
`ifdef IMM_EXT_TRUNC_CHECK_EN
                        m_trunc <= res_trunc;
`endif
                    end else if (in_xfer) begin
                        s_imm   <= res_imm;
                        s_mode  <= in_mode;
`ifdef IMM_EXT_TRUNC_CHECK_EN
                        s_trunc <= res_trunc;
`endif
                        state   <= ST_TWO;
                    end else if (out_xfer) begin
                        state   <= ST_EMPTY;
                    end
                end
                state == ST_TWO: begin
                    if (out_xfer) begin
                        m_imm   <= s_imm;
                        m_mode  <= s_mode;
`ifdef IMM_EXT_TRUNC_CHECK_EN
                        m_trunc <= s_trunc;
`endif
                        state   <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe (16/32 main, 8/12 and 16/16 side instances).
// Trunc checks compile in when IMM_EXT_TRUNC_CHECK_EN is defined.
module tb_imm_ext_pipe;

    typedef struct {
        logic [31:0] imm;
        logic [1:0]  mode;
        logic        trunc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: 16 -> 32
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [1:0]  a_in_mode = '0;
    logic [15:0] a_in_imm = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [31:0] a_out_imm;
    logic [1:0]  a_out_mode;

    // Narrow instance: 8 -> 12
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [1:0]  b_in_mode = '0;
    logic [7:0]  b_in_imm = '0;
    logic        b_out_valid;
    logic [11:0] b_out_imm;
    logic [1:0]  b_out_mode;

    // Equal-width instance: 16 -> 16
    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic [1:0]  c_in_mode = '0;
    logic [15:0] c_in_imm = '0;
    logic        c_out_valid;
    logic [15:0] c_out_imm;
    logic [1:0]  c_out_mode;

`ifdef IMM_EXT_TRUNC_CHECK_EN
    logic a_out_trunc;
    logic b_out_trunc;
    logic c_out_trunc;
`endif

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_mode   (a_in_mode),
        .in_imm    (a_in_imm),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_imm   (a_out_imm),
        .out_mode  (a_out_mode)
`ifdef IMM_EXT_TRUNC_CHECK_EN
        ,
        .out_trunc (a_out_trunc)
`endif
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(12)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_mode   (b_in_mode),
        .in_imm    (b_in_imm),
        .out_valid (b_out_valid),
        .out_ready (1'b1),
        .out_imm   (b_out_imm),
        .out_mode  (b_out_mode)
`ifdef IMM_EXT_TRUNC_CHECK_EN
        ,
        .out_trunc (b_out_trunc)
`endif
    );

    imm_ext_pipe #(.IN_W(16), .OUT_W(16)) u_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_mode   (c_in_mode),
        .in_imm    (c_in_imm),
        .out_valid (c_out_valid),
        .out_ready (1'b1),
        .out_imm   (c_out_imm),
        .out_mode  (c_out_mode)
`ifdef IMM_EXT_TRUNC_CHECK_EN
        ,
        .out_trunc (c_out_trunc)
`endif
    );

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t exp_c[$];
    exp_t ea, eb, ec;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", n, act, exp);
        end
    endtask

    task automatic fail_now(input string n);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/extra, want event", n);
    endtask

    // Reference for the 16 -> 32 instance, written arithmetically
    function automatic logic [31:0] ref_a(input logic [1:0] m,
                                          input logic [15:0] i);
        int s;
        s = i[15] ? int'(i) - 65536 : int'(i);
        case (m)
            2'd0:    return {16'h0000, i};
            2'd1:    return 32'(s);
            2'd2:    return {i, 16'h0000};
            default: return 32'(s * 4);
        endcase
    endfunction

    // Monitors: pop and compare on each output transfer
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) fail_now("a_unexpected");
            else begin
                ea = exp_a.pop_front();
                chk("a_imm", a_out_imm, ea.imm);
                chk("a_mode", 32'(a_out_mode), 32'(ea.mode));
`ifdef IMM_EXT_TRUNC_CHECK_EN
                chk("a_trunc", 32'(a_out_trunc), 32'(ea.trunc));
`endif
            end
        end
        if (rst_n && b_out_valid) begin
            if (exp_b.size() == 0) fail_now("b_unexpected");
            else begin
                eb = exp_b.pop_front();
                chk("b_imm", 32'(b_out_imm), eb.imm);
                chk("b_mode", 32'(b_out_mode), 32'(eb.mode));
`ifdef IMM_EXT_TRUNC_CHECK_EN
                chk("b_trunc", 32'(b_out_trunc), 32'(eb.trunc));
`endif
            end
        end
        if (rst_n && c_out_valid) begin
            if (exp_c.size() == 0) fail_now("c_unexpected");
            else begin
                ec = exp_c.pop_front();
                chk("c_imm", 32'(c_out_imm), ec.imm);
                chk("c_mode", 32'(c_out_mode), 32'(ec.mode));
`ifdef IMM_EXT_TRUNC_CHECK_EN
                chk("c_trunc", 32'(c_out_trunc), 32'(ec.trunc));
`endif
            end
        end
    end

    // Present one input; leaves in_valid high for back-to-back use
    task automatic send_a(input logic [1:0] m, input logic [15:0] i,
                          input logic [31:0] e);
        int t = 0;
        a_in_valid = 1'b1;
        a_in_mode  = m;
        a_in_imm   = i;
        while (!a_in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!a_in_ready) begin
            fail_now("a_send_timeout");
            a_in_valid = 1'b0;
        end else begin
            exp_a.push_back('{e, m, 1'b0});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_b(input logic [1:0] m, input logic [7:0] i,
                          input logic [11:0] e, input logic tr);
        chk("b_in_ready", 32'(b_in_ready), 32'd1);
        b_in_valid = 1'b1;
        b_in_mode  = m;
        b_in_imm   = i;
        exp_b.push_back('{32'(e), m, tr});
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic send_c(input logic [1:0] m, input logic [15:0] i,
                          input logic [15:0] e, input logic tr);
        chk("c_in_ready", 32'(c_in_ready), 32'd1);
        c_in_valid = 1'b1;
        c_in_mode  = m;
        c_in_imm   = i;
        exp_c.push_back('{32'(e), m, tr});
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
    endtask

    int  c0;
    bit  rnd_done;

    initial begin
        // Reset values
        #13;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_imm", a_out_imm, 32'd0);
        chk("rst_out_mode", 32'(a_out_mode), 32'd0);
`ifdef IMM_EXT_TRUNC_CHECK_EN
        chk("rst_out_trunc", 32'(a_out_trunc), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four modes back to back at full rate
        a_out_ready = 1'b1;
        c0 = cyc;
        send_a(2'd0, 16'h8001, 32'h0000_8001);
        send_a(2'd1, 16'h8001, 32'hFFFF_8001);
        send_a(2'd2, 16'h8001, 32'h8001_0000);
        send_a(2'd3, 16'h8001, 32'hFFFE_0004);
        a_in_valid = 1'b0;
        chk("throughput_cycles", 32'(cyc - c0), 32'd4);
        repeat (3) @(posedge clk);
        #1;

        // Stall: two accepted, third held off, outputs stable
        a_out_ready = 1'b0;
        send_a(2'd1, 16'h1234, 32'h0000_1234);
        chk("in_ready_after_1st", 32'(a_in_ready), 32'd1);
        send_a(2'd2, 16'hABCD, 32'hABCD_0000);
        chk("in_ready_after_2nd", 32'(a_in_ready), 32'd0);
        a_in_valid = 1'b1;
        a_in_mode  = 2'd3;
        a_in_imm   = 16'h0010;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", 32'(a_in_ready), 32'd0);
            chk("stall_out_valid", 32'(a_out_valid), 32'd1);
            chk("stall_out_imm", a_out_imm, 32'h0000_1234);
            chk("stall_out_mode", 32'(a_out_mode), 32'd1);
        end
        a_out_ready = 1'b1;
        send_a(2'd3, 16'h0010, 32'h0000_0040);
        a_in_valid = 1'b0;
        chk("in_ready_released", 32'(a_in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Random handshake against the arithmetic reference
        rnd_done = 1'b0;
        fork
            begin
                logic [1:0]  m;
                logic [15:0] i;
                for (int n = 0; n < 3000; n++) begin
                    while ($urandom % 2) begin
                        a_in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    m = 2'($urandom);
                    i = 16'($urandom);
                    send_a(m, i, ref_a(m, i));
                end
                a_in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    a_out_ready = 1'($urandom % 2);
                end
            end
        join
        a_out_ready = 1'b1;
        c0 = 0;
        while (exp_a.size() != 0 && c0 < 100) begin
            @(posedge clk);
            #1;
            c0++;
        end
        chk("random_drained", 32'(exp_a.size()), 32'd0);

        // Async reset while both entries are full
        a_out_ready = 1'b0;
        send_a(2'd0, 16'h0055, 32'h0000_0055);
        send_a(2'd0, 16'h00AA, 32'h0000_00AA);
        a_in_valid = 1'b0;
        chk("two_in_ready", 32'(a_in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(a_out_valid), 32'd0);
        chk("async_in_ready", 32'(a_in_ready), 32'd1);
        exp_a.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        send_a(2'd1, 16'h7FFF, 32'h0000_7FFF);
        a_in_valid = 1'b0;

        // Narrow 8 -> 12
        send_b(2'd1, 8'h80, 12'hF80, 1'b0);
        send_b(2'd3, 8'h7F, 12'h1FC, 1'b0);
        send_b(2'd0, 8'h80, 12'h080, 1'b0);
        send_b(2'd2, 8'h12, 12'h200, 1'b1);

        // Equal width 16 -> 16
        send_c(2'd2, 16'h0001, 16'h0000, 1'b1);
        send_c(2'd3, 16'h3FFF, 16'hFFFC, 1'b1);
        send_c(2'd3, 16'hFFFF, 16'hFFFC, 1'b0);
        send_c(2'd1, 16'h8001, 16'h8001, 1'b0);

        c0 = 0;
        while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 &&
               c0 < 50) begin
            @(posedge clk);
            #1;
            c0++;
        end
        chk("final_drained",
            32'(exp_a.size() + exp_b.size() + exp_c.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
